aes_encrypt: RTL and testbench

// - AES-128 encryption core per FIPS-197: one 128-bit plaintext block plus 128-bit key in, one ciphertext block out.
// - Iterative: one round per clock, round keys expanded on the fly; no key-schedule RAM.
// - Sits between the host data path and the output register stage; encrypt-only, no decrypt.

---
 rtl/aes_encrypt.sv | 122 ++++++++++++
 tb/tb_aes_encrypt.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt.sv
// aes_encrypt: iterative AES-128 encryption core, one round per clock with on-the-fly key expansion
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, aborts any block in flight
//   start    1-cycle request, accepted only while idle
//   data_in  128-bit plaintext, [127:120] = byte 0, column-major state
//   key_in   128-bit cipher key, [127:120] = byte 0
//   data_out 128-bit ciphertext, holds last result until next completion
//   busy     high while a block is in flight
//   done     1-cycle pulse when data_out is newly valid
module aes_encrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at index r + 4c; ShiftRows pulls from column (c + r) mod 4
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    // 2*a0 ^ 3*a1 ^ a2 ^ a3, rotated per output row
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++)
                a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] state_q, key_q, data_out_q, state_d, key_d, sr;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic         busy_q, done_q;

    always_comb begin
        sr      = sub_shift(state_q);
        key_d   = next_key(key_q, rcon_q);
        state_d = (round_q == 4'd10 ? sr : mix_columns(sr)) ^ key_d;
    end

    // Rcon doubles in GF(2^8) each round: 01..80 then wraps through the 0x1b reduction to 1b, 36
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            round_q    <= '0;
            rcon_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q && start) begin
                state_q <= data_in ^ key_in;
                key_q   <= key_in;
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                state_q <= state_d;
                key_q   <= key_d;
                rcon_q  <= xt(rcon_q);
                if (round_q == 4'd10) begin
                    data_out_q <= state_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    round_q    <= '0;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_aes_encrypt.sv
// tb_aes_encrypt: scoreboard bench for aes_encrypt against a GF(2^8) byte-level AES-128 model
module tb_aes_encrypt;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [127:0] data_in, key_in, data_out;
    logic         busy, done;

    aes_encrypt dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key_in(key_in),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int           checks = 0, fails = 0, edge_cnt = 0;
    logic [127:0] exp_q [$];
    int           lat_q [$];
    logic [7:0]   sb [256];
    logic         prev_done = 1'b0;

    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Multiplicative inverse by search, then the FIPS affine transform
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st [16], tmp [16], w [176], t [4], rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            st[i] = pt[127-8*i -: 8];
            w[i]  = k[127-8*i -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
            if (i % 16 == 0) begin
                t = '{sb[w[i-3]] ^ rc, sb[w[i-2]], sb[w[i-1]], sb[w[i-4]]};
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
            st = tmp;
            if (rnd < 10)
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        st[r+4*c] = gmul(8'h02, tmp[4*c+r]) ^ gmul(8'h03, tmp[4*c+(r+1)%4])
                                  ^ tmp[4*c+(r+2)%4] ^ tmp[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("done_pulse_width", 128'(prev_done), 128'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(done), 128'(0));
            end else begin
                check("ciphertext", data_out, exp_q.pop_front());
                check("latency", 128'(edge_cnt), 128'(lat_q.pop_front()));
                check("busy_at_done", 128'(busy), 128'(0));
            end
        end
        prev_done <= done;
    end

    // Called at a negedge; the following posedge is the start edge
    task automatic issue(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
        data_in = pt;
        key_in  = k;
        start   = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(edge_cnt + 11);
        @(negedge clk);
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt, k, e;
        int n;
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        key_in = '0;
        build_sbox();
        repeat (2) @(negedge clk);
        check("reset_data_out", data_out, 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        issue(C1_PT, C1_K, C1_CT);
        wait_idle();
        issue(B_PT, B_K, B_CT);
        wait_idle();
        issue('0, '0, Z_CT);
        wait_idle();
        pt = 128'haaeabaaeabaaeabaaeabaaeabaaeabaa;
        k  = 128'hf1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1;
        e  = aes_ref(pt, k);
        issue(pt, k, e);
        check("no_intermediate_output", data_out, Z_CT);
        repeat (2) @(negedge clk);
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignores_start", 128'(busy), 128'(1));
        wait_idle();
        check("data_out_hold", data_out, e);
        issue(C1_PT, C1_K, C1_CT);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("b2b_done_timeout", 128'(done), 128'(1));
        issue(B_PT, B_K, B_CT);
        wait_idle();
        issue(C1_PT, C1_K, C1_CT);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        check("abort_data_out", data_out, 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        repeat (15) @(negedge clk);
        issue(C1_PT, C1_K, C1_CT);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            issue(pt, k, aes_ref(pt, k));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
